// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for a MIPS subset (addu/subu/ori/lui/lw/sw/beq/j/jal/jr).
// Optional feature macro MC_CTRL_ILLEGAL_TRAP_EN: unsupported instructions halt instead of NOP.
module mc_ctrl (
    input  logic        mc_ctrl_i_clk,
    input  logic        mc_ctrl_i_rst_n,
    input  logic [31:0] mc_ctrl_i_instr,
    input  logic        mc_ctrl_i_zero,
    input  logic        mc_ctrl_i_mem_ack,
    output logic        mc_ctrl_o_mem_req,
    output logic        mc_ctrl_o_mem_we,
    output logic        mc_ctrl_o_mem_isel,
    output logic        mc_ctrl_o_ir_we,
    output logic        mc_ctrl_o_pc_we,
    output logic [1:0]  mc_ctrl_o_pc_src,
    output logic [2:0]  mc_ctrl_o_alu_op,
    output logic [2:0]  mc_ctrl_o_alu_op2_sel,
    output logic [2:0]  mc_ctrl_o_reg_waddr_sel,
    output logic [2:0]  mc_ctrl_o_reg_wdata_sel,
    output logic        mc_ctrl_o_reg_we,
    output logic [2:0]  mc_ctrl_o_state,
    output logic [31:0] mc_ctrl_o_retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;
    localparam logic [1:0] PcReg    = 2'd3;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluOr  = 3'd2;
    localparam logic [2:0] AluLui = 3'd3;

    localparam logic [2:0] SelReg  = 3'd0;
    localparam logic [2:0] SelExt  = 3'd1;
    localparam logic [2:0] WaRd    = 3'd0;
    localparam logic [2:0] WaRt    = 3'd1;
    localparam logic [2:0] WaLink  = 3'd2;
    localparam logic [2:0] WdAlu   = 3'd0;
    localparam logic [2:0] WdMem   = 3'd1;
    localparam logic [2:0] WdLink  = 3'd2;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;

    logic [5:0] opcode, funct;
    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_jr;
    logic is_supported;
    logic unused_instr;

    logic       mem_req, mem_we, mem_isel, ir_we, pc_we, reg_we;
    logic [1:0] pc_src;
    logic [2:0] alu_op, op2_sel, waddr_sel, wdata_sel;
    logic       retire;

    assign opcode       = mc_ctrl_i_instr[31:26];
    assign funct        = mc_ctrl_i_instr[5:0];
    assign unused_instr = ^mc_ctrl_i_instr[25:6];

    always_comb begin
        is_addu = (opcode == OpRtype) && (funct == FnAddu);
        is_subu = (opcode == OpRtype) && (funct == FnSubu);
        is_jr   = (opcode == OpRtype) && (funct == FnJr);
        is_ori  = (opcode == OpOri);
        is_lui  = (opcode == OpLui);
        is_lw   = (opcode == OpLw);
        is_sw   = (opcode == OpSw);
        is_beq  = (opcode == OpBeq);
        is_j    = (opcode == OpJ);
        is_jal  = (opcode == OpJal);
        is_supported = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq |
                       is_j | is_jal;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_isel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        pc_src    = PcPlus4;
        alu_op    = AluAdd;
        op2_sel   = SelReg;
        waddr_sel = WaRd;
        wdata_sel = WdAlu;

        case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_isel = 1'b1;
                if (mc_ctrl_i_mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PcPlus4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_j) begin
                    pc_we   = 1'b1;
                    pc_src  = PcJump;
                    state_d = StFetch;
                end else if (is_jal) begin
                    pc_we     = 1'b1;
                    pc_src    = PcJump;
                    reg_we    = 1'b1;
                    waddr_sel = WaLink;
                    wdata_sel = WdLink;
                    state_d   = StFetch;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = PcReg;
                    state_d = StFetch;
                end else if (is_supported) begin
                    state_d = StExec;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StFetch;
`endif
                end
            end
            StExec: begin
                state_d = StFetch;
                if (is_addu || is_subu) begin
                    alu_op  = is_subu ? AluSub : AluAdd;
                    op2_sel = SelReg;
                    state_d = StWb;
                end else if (is_ori) begin
                    alu_op  = AluOr;
                    op2_sel = SelExt;
                    state_d = StWb;
                end else if (is_lui) begin
                    alu_op  = AluLui;
                    op2_sel = SelExt;
                    state_d = StWb;
                end else if (is_lw || is_sw) begin
                    alu_op  = AluAdd;
                    op2_sel = SelExt;
                    state_d = StMem;
                end else if (is_beq) begin
                    alu_op  = AluSub;
                    op2_sel = SelReg;
                    pc_we   = mc_ctrl_i_zero;
                    pc_src  = PcBranch;
                end
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_isel = 1'b0;
                mem_we   = is_sw;
                if (mc_ctrl_i_mem_ack) begin
                    state_d = is_lw ? StWb : StFetch;
                end
            end
            StWb: begin
                reg_we  = 1'b1;
                state_d = StFetch;
                if (is_ori || is_lui) begin
                    waddr_sel = WaRt;
                end else if (is_lw) begin
                    waddr_sel = WaRt;
                    wdata_sel = WdMem;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Only instruction-ending transitions count; stray codes 6/7 recovering to FETCH do not.
    always_comb begin
        retire = (state_d == StFetch) &&
                 (state_q inside {StDecode, StExec, StMem, StWb});
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge mc_ctrl_i_clk or negedge mc_ctrl_i_rst_n) begin
        if (!mc_ctrl_i_rst_n) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Reset forces every strobe low immediately, even with a request outstanding.
    assign mc_ctrl_o_mem_req       = mc_ctrl_i_rst_n & mem_req;
    assign mc_ctrl_o_mem_we        = mc_ctrl_i_rst_n & mem_we;
    assign mc_ctrl_o_mem_isel      = mc_ctrl_i_rst_n & mem_isel;
    assign mc_ctrl_o_ir_we         = mc_ctrl_i_rst_n & ir_we;
    assign mc_ctrl_o_pc_we         = mc_ctrl_i_rst_n & pc_we;
    assign mc_ctrl_o_reg_we        = mc_ctrl_i_rst_n & reg_we;
    assign mc_ctrl_o_pc_src        = mc_ctrl_i_rst_n ? pc_src    : 2'd0;
    assign mc_ctrl_o_alu_op        = mc_ctrl_i_rst_n ? alu_op    : 3'd0;
    assign mc_ctrl_o_alu_op2_sel   = mc_ctrl_i_rst_n ? op2_sel   : 3'd0;
    assign mc_ctrl_o_reg_waddr_sel = mc_ctrl_i_rst_n ? waddr_sel : 3'd0;
    assign mc_ctrl_o_reg_wdata_sel = mc_ctrl_i_rst_n ? wdata_sel : 3'd0;
    assign mc_ctrl_o_state         = state_q;
    assign mc_ctrl_o_retired       = retired_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 mc_ctrl_i_clk  in  1  single clock; all state changes on rising edge.
REQ-002 mc_ctrl_i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 mc_ctrl_i_instr  in  32  instruction register contents; opcode [31:26], funct [5:0].
REQ-004 mc_ctrl_i_zero  in  1  ALU zero flag.
REQ-005 mc_ctrl_i_mem_ack  in  1  memory completion, one-cycle pulse.
REQ-006 mc_ctrl_o_mem_req / o_mem_we / o_mem_isel  out  1 each  memory request, write strobe, instruction-space select.
REQ-007 mc_ctrl_o_ir_we / o_pc_we  out  1 each  IR load, PC load.
REQ-008 mc_ctrl_o_pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register.
REQ-009 mc_ctrl_o_alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI.
REQ-010 mc_ctrl_o_alu_op2_sel / o_reg_waddr_sel / o_reg_wdata_sel  out  3 each  operand-2 select (0=reg, 1=ext), write-address select (0=rd, 1=rt, 2=link), write-data select (0=ALU, 1=mem, 2=link).
REQ-011 mc_ctrl_o_reg_we  out  1  register-file write enable.
REQ-012 mc_ctrl_o_state  out  3  current state; mc_ctrl_o_retired  out  32  retired-instruction count.

Function
REQ-013 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next edge.
REQ-014 Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.
REQ-015 Outputs SHALL be combinational from state, instr, zero and mem_ack; in any state, unlisted enables SHALL be 0 and unlisted selects SHALL be 0.
REQ-016 FETCH: mem_req=1, mem_isel=1; held until mem_ack; in the ack cycle ir_we=1, pc_we=1, pc_src=0, then DECODE; without ack, stay in FETCH.
REQ-017 DECODE (1 cycle): j gives pc_we=1, pc_src=2 -> FETCH; jal gives pc_we=1, pc_src=2, reg_we=1, waddr_sel=2, wdata_sel=2 -> FETCH; jr gives pc_we=1, pc_src=3 -> FETCH; other supported instructions -> EXEC.
REQ-018 EXEC (1 cycle): addu/subu use ADD/SUB with op2_sel=0 -> WB; ori uses OR with op2_sel=1 -> WB; lui uses LUI with op2_sel=1 -> WB; lw/sw use ADD with op2_sel=1 -> MEM; beq uses SUB with op2_sel=0, pc_we=zero, pc_src=1 -> FETCH.
REQ-019 MEM: mem_req=1, mem_isel=0, mem_we=1 for sw only; held until mem_ack; on ack, sw -> FETCH and lw -> WB.
REQ-020 WB (1 cycle): reg_we=1; addu/subu use waddr_sel=0, wdata_sel=0; ori/lui use waddr_sel=1, wdata_sel=0; lw uses waddr_sel=1, wdata_sel=1; then FETCH.
REQ-021 Once asserted, mem_req SHALL stay high until the ack cycle, and the request attributes SHALL stay stable during that time.
REQ-022 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-023 retired SHALL increment by 1 on every edge that leaves DECODE, EXEC, MEM or WB for FETCH; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 Latency in cycles (with zero-wait memory, i.e. ack on the first request cycle): j/jal/jr 2, beq 3, addu/subu/ori/lui 4, sw 4, lw 5.

Reset
REQ-025 On rst_n=0: state=FETCH and retired=0 immediately; all enables and mem_req=0 while reset is held, including when reset interrupts an outstanding request.
REQ-026 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally; mem_req SHALL be high in the first cycle after release.

Configuration
REQ-027 Macro MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode/funct in DECODE SHALL go to HALT, where all enables are 0 and o_state=5; only reset exits HALT.
- Undefined: an unsupported opcode/funct SHALL go DECODE -> FETCH as a NOP, counted in retired; HALT is unreachable.

Verification
REQ-028 Reset mid-FETCH with mem_req=1, then assert rst_n=0 -> mem_req=0 in the same cycle, state=0, retired=0.
REQ-029 addu 0x00851021, zero-wait memory -> states 0,1,2,4,0; reg_we=1 in WB with waddr_sel=0; retired +1 after 4 cycles.
REQ-030 lw 0x8C820004 with ack delayed 3 cycles in MEM -> mem_req/isel stable while waiting; WB has wdata_sel=1, waddr_sel=1.
REQ-031 beq 0x10850003 with zero=1, then zero=0 -> pc_we=1, pc_src=1 in EXEC; then pc_we=0; both return to FETCH.
REQ-032 jal 0x0C000010 -> DECODE has pc_we=1, pc_src=2, reg_we=1, waddr_sel=2, wdata_sel=2; 2 cycles total.
REQ-033 opcode 0x3F, run with and without MC_CTRL_ILLEGAL_TRAP_EN -> with the macro, state=5 persists; without it, state returns to FETCH and retired increments.
